// File: rtl/stopwatch_core.sv
// BCD MM:SS.t stopwatch time base driven by a 10 Hz tick and two button pulses.
// Define STOPWATCH_WRAP_EN to wrap at the terminal value instead of saturating.
module stopwatch_core #(
    parameter int MAX_MIN = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_10hz,
    input  logic       btn_start_stop,
    input  logic       btn_lap_reset,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] tenths,
    output logic       running,
    output logic       lap_hold,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP,
        LAP
    } state_t;

    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
        logic [3:0] tn;
    } bcd_t;

    localparam logic [3:0] MAX_MT = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_MO = 4'(MAX_MIN % 10);

    state_t state, state_n;
    bcd_t   live, live_n, lap, lap_n, inc, disp;
    logic   ovf, ovf_n;
    logic   counting, at_max;
`ifndef STOPWATCH_WRAP_EN
    logic   sat;
`endif

    assign counting = (state == RUN) || (state == LAP);
    assign at_max   = (live == {MAX_MT, MAX_MO, 4'd5, 4'd9, 4'd9});

    // Ripple-carry BCD increment; the terminal value is handled separately.
    always_comb begin
        inc = live;
        if (live.tn != 4'd9) begin
            inc.tn = live.tn + 4'd1;
        end else begin
            inc.tn = 4'd0;
            if (live.so != 4'd9) begin
                inc.so = live.so + 4'd1;
            end else begin
                inc.so = 4'd0;
                if (live.st != 4'd5) begin
                    inc.st = live.st + 4'd1;
                end else begin
                    inc.st = 4'd0;
                    if (live.mo != 4'd9) begin
                        inc.mo = live.mo + 4'd1;
                    end else begin
                        inc.mo = 4'd0;
                        inc.mt = live.mt + 4'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        live_n  = live;
        lap_n   = lap;
        ovf_n   = ovf;
`ifdef STOPWATCH_WRAP_EN
        ovf_n   = 1'b0;
`else
        sat     = 1'b0;
`endif
        if (counting && tick_10hz) begin
            if (!at_max) begin
                live_n = inc;
            end else begin
`ifdef STOPWATCH_WRAP_EN
                live_n = '0;
                ovf_n  = 1'b1;
`else
                ovf_n  = 1'b1;
                sat    = 1'b1;
`endif
            end
        end
        unique case (state)
            IDLE: begin
                if (btn_start_stop) state_n = RUN;
            end
            RUN: begin
                if (btn_start_stop) begin
                    state_n = STOP;
                end else if (btn_lap_reset) begin
                    state_n = LAP;
                    lap_n   = live;
                end
            end
            LAP: begin
                if (btn_start_stop)     state_n = STOP;
                else if (btn_lap_reset) state_n = RUN;
            end
            STOP: begin
                // A saturated counter cannot be resumed, only cleared.
                if (btn_start_stop && !ovf) begin
                    state_n = RUN;
                end else if (btn_lap_reset) begin
                    state_n = IDLE;
                    live_n  = '0;
                    ovf_n   = 1'b0;
                end
            end
        endcase
`ifndef STOPWATCH_WRAP_EN
        if (sat) state_n = STOP;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            live  <= '0;
            lap   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            live  <= live_n;
            lap   <= lap_n;
            ovf   <= ovf_n;
        end
    end

    assign disp     = (state == LAP) ? lap : live;
    assign min_tens = disp.mt;
    assign min_ones = disp.mo;
    assign sec_tens = disp.st;
    assign sec_ones = disp.so;
    assign tenths   = disp.tn;
    assign running  = counting;
    assign lap_hold = (state == LAP);
    assign overflow = ovf;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: tenths-count reference model plus
// directed literal checks and randomized button/tick traffic.
module tb_stopwatch_core;

    localparam int MM   = 1;
    localparam int MAXT = (MM + 1) * 600 - 1;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_STOP = 2;
    localparam int S_LAP  = 3;

    logic       clk;
    logic       rst;
    logic       tick_10hz;
    logic       btn_start_stop;
    logic       btn_lap_reset;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones, tenths;
    logic       running, lap_hold, overflow;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    int m_state = S_IDLE;
    int m_live  = 0;
    int m_lap   = 0;
    int m_ovf   = 0;

    stopwatch_core #(.MAX_MIN(MM)) dut (
        .clk            (clk),
        .rst            (rst),
        .tick_10hz      (tick_10hz),
        .btn_start_stop (btn_start_stop),
        .btn_lap_reset  (btn_lap_reset),
        .min_tens       (min_tens),
        .min_ones       (min_ones),
        .sec_tens       (sec_tens),
        .sec_ones       (sec_ones),
        .tenths         (tenths),
        .running        (running),
        .lap_hold       (lap_hold),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model: elapsed time as a plain count of tenths.
    always @(posedge clk) begin
        int nl, ns;
        bit ss, lr, force_stop;
        ss = btn_start_stop;
        lr = btn_lap_reset;
        if (rst) begin
            m_state = S_IDLE;
            m_live  = 0;
            m_lap   = 0;
            m_ovf   = 0;
        end else begin
            nl = m_live;
            ns = m_state;
            force_stop = 0;
`ifdef STOPWATCH_WRAP_EN
            m_ovf = 0;
`endif
            if ((m_state == S_RUN || m_state == S_LAP) && tick_10hz) begin
                if (m_live == MAXT) begin
`ifdef STOPWATCH_WRAP_EN
                    nl    = 0;
                    m_ovf = 1;
`else
                    m_ovf      = 1;
                    force_stop = 1;
`endif
                end else begin
                    nl = m_live + 1;
                end
            end
            case (m_state)
                S_IDLE: if (ss) ns = S_RUN;
                S_RUN: begin
                    if (ss) ns = S_STOP;
                    else if (lr) begin
                        ns    = S_LAP;
                        m_lap = m_live;
                    end
                end
                S_LAP: begin
                    if (ss) ns = S_STOP;
                    else if (lr) ns = S_RUN;
                end
                default: begin
                    if (ss && m_ovf == 0) ns = S_RUN;
                    else if (lr) begin
                        ns    = S_IDLE;
                        nl    = 0;
                        m_ovf = 0;
                    end
                end
            endcase
            if (force_stop) ns = S_STOP;
            m_state = ns;
            m_live  = nl;
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int d, mins, secs;
        if (chk_en) begin
            d    = (m_state == S_LAP) ? m_lap : m_live;
            mins = d / 600;
            secs = (d / 10) % 60;
            chk("cmp_min_tens", int'(min_tens), mins / 10);
            chk("cmp_min_ones", int'(min_ones), mins % 10);
            chk("cmp_sec_tens", int'(sec_tens), secs / 10);
            chk("cmp_sec_ones", int'(sec_ones), secs % 10);
            chk("cmp_tenths",   int'(tenths),   d % 10);
            chk("cmp_running",  int'(running),
                (m_state == S_RUN || m_state == S_LAP) ? 1 : 0);
            chk("cmp_lap_hold", int'(lap_hold), (m_state == S_LAP) ? 1 : 0);
            chk("cmp_overflow", int'(overflow), m_ovf);
        end
    end

    task automatic lit(input string nm, input int mt, input int mo,
                       input int st, input int so, input int tn,
                       input int run, input int lh, input int ov);
        chk({nm, ".mt"},  int'(min_tens), mt);
        chk({nm, ".mo"},  int'(min_ones), mo);
        chk({nm, ".st"},  int'(sec_tens), st);
        chk({nm, ".so"},  int'(sec_ones), so);
        chk({nm, ".tn"},  int'(tenths),   tn);
        chk({nm, ".run"}, int'(running),  run);
        chk({nm, ".lap"}, int'(lap_hold), lh);
        chk({nm, ".ovf"}, int'(overflow), ov);
    endtask

    task automatic step(input bit ss, input bit lr, input bit tk,
                        input bit r = 0);
        btn_start_stop = ss;
        btn_lap_reset  = lr;
        tick_10hz      = tk;
        rst            = r;
        @(negedge clk);
        btn_start_stop = 0;
        btn_lap_reset  = 0;
        tick_10hz      = 0;
        rst            = 0;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(0, 0, 1);
    endtask

    initial begin
        rst            = 1;
        tick_10hz      = 0;
        btn_start_stop = 0;
        btn_lap_reset  = 0;
        repeat (2) @(negedge clk);
        rst    = 0;
        chk_en = 1;
        lit("reset", 0, 0, 0, 0, 0, 0, 0, 0);

        step(1, 0, 0);
        ticks(25);
        lit("run25", 0, 0, 0, 2, 5, 1, 0, 0);
        step(1, 0, 0);
        ticks(10);
        lit("stop_hold", 0, 0, 0, 2, 5, 0, 0, 0);
        step(0, 1, 0);
        lit("clear", 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0);
        lit("idle_lr", 0, 0, 0, 0, 0, 0, 0, 0);

        step(1, 0, 0);
        ticks(34);
        lit("pre_lap", 0, 0, 0, 3, 4, 1, 0, 0);
        step(0, 1, 0);
        lit("lap_frz", 0, 0, 0, 3, 4, 1, 1, 0);
        ticks(20);
        lit("lap_20", 0, 0, 0, 3, 4, 1, 1, 0);
        step(0, 1, 0);
        lit("lap_rel", 0, 0, 0, 5, 4, 1, 0, 0);

        step(1, 0, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        ticks(11);
        step(1, 1, 1);
        lit("triple", 0, 0, 0, 1, 2, 0, 0, 0);

        step(1, 0, 0);
        ticks(58);
        step(1, 0, 0);
        lit("stop70", 0, 0, 0, 7, 0, 0, 0, 0);
        step(0, 1, 0);
        lit("clr70", 0, 0, 0, 0, 0, 0, 0, 0);

        step(1, 0, 0);
        ticks(99);
        lit("pre10", 0, 0, 0, 9, 9, 1, 0, 0);
        ticks(1);
        lit("carry10", 0, 0, 1, 0, 0, 1, 0, 0);
        ticks(499);
        lit("pre_min", 0, 0, 5, 9, 9, 1, 0, 0);
        ticks(1);
        lit("carry_min", 0, 1, 0, 0, 0, 1, 0, 0);

        step(0, 0, 0, 1);
        step(1, 0, 0);
        ticks(456);
        lit("at456", 0, 0, 4, 5, 6, 1, 0, 0);
        step(0, 0, 1, 1);
        lit("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0);

        step(1, 0, 0);
        ticks(1199);
        lit("term", 0, 1, 5, 9, 9, 1, 0, 0);
        ticks(1);
`ifdef STOPWATCH_WRAP_EN
        lit("wrap", 0, 0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0);
        lit("wrap_end", 0, 0, 0, 0, 0, 1, 0, 0);
`else
        lit("sat", 0, 1, 5, 9, 9, 0, 0, 1);
        step(1, 0, 0);
        lit("sat_ss_ign", 0, 1, 5, 9, 9, 0, 0, 1);
        step(0, 1, 0);
        lit("sat_clr", 0, 0, 0, 0, 0, 0, 0, 0);
`endif

        step(0, 0, 0, 1);
        for (int i = 0; i < 4000; i++)
            step($urandom % 40 == 0, $urandom % 30 == 0,
                 $urandom % 2 == 0, $urandom % 1500 == 0);
        for (int i = 0; i < 5000; i++)
            step($urandom % 300 == 0, $urandom % 200 == 0,
                 $urandom % 8 != 0, $urandom % 6000 == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
